// File: rtl/vending_multi_pkg.sv
// rtl/vending_multi_pkg.sv - shared types and defaults for the multi-product vending machine
// Contents: FSM state enum, default stock level after reset/restock, default price table.
package vending_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vm_state_e;

    localparam int DEFAULT_STOCK_INIT = 3;

    // Product 3..0 prices, packed MSB-first so index 0 is the cheapest item.
    localparam logic [3:0][5:0] DEFAULT_PRICES = {6'd7, 6'd5, 6'd3, 6'd2};

endpackage

// File: rtl/vm_stock_bank.sv
// rtl/vm_stock_bank.sv - per-product stock counters with decrement, restock and empty flags
// Ports:
//   clk, rst            : clock, synchronous active-high reset (all counters -> STOCK_INIT)
//   dec_valid, dec_id   : remove one item of product dec_id
//   restock_valid/_id   : reload product restock_id to STOCK_INIT
//   empty               : per-product flag, high when that counter is zero
module vm_stock_bank
    import vending_multi_pkg::*;
#(
    parameter int NUM_PROD   = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = DEFAULT_STOCK_INIT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dec_valid,
    input  logic [$clog2(NUM_PROD)-1:0] dec_id,
    input  logic                        restock_valid,
    input  logic [$clog2(NUM_PROD)-1:0] restock_id,
    output logic [NUM_PROD-1:0]         empty
);

    logic [STOCK_W-1:0] stock_q [NUM_PROD];
    logic [STOCK_W-1:0] stock_d [NUM_PROD];

    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            stock_d[i] = stock_q[i];
            empty[i]   = (stock_q[i] == '0);
        end
        if (restock_valid) begin
            stock_d[restock_id] = STOCK_W'(STOCK_INIT);
        end
        // Guard against wrap-around; the controller never decrements an empty slot.
        if (dec_valid && (stock_q[dec_id] != '0)) begin
            stock_d[dec_id] = stock_q[dec_id] - STOCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PROD; i++) begin
            if (rst) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end else begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

endmodule

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-product vending machine controller
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   coin_valid, coin          : coin insert strobe and value
//   sel_valid, sel            : product select strobe and index
//   cancel                    : refund request (honoured only while holding credit)
//   restock_valid, restock_id : refill one product (honoured only in IDLE)
//   out, out_id               : one-cycle dispense pulse and product
//   change_valid, change      : one-cycle refund pulse and amount
//   credit, busy              : held credit, high while dispensing / returning change
//   coin_reject, err_funds, err_soldout : one-cycle error pulses
module vending_machine_multi
    import vending_multi_pkg::*;
#(
    parameter int NUM_PROD   = 4,
    parameter int COIN_W     = 3,
    parameter int CREDIT_W   = 6,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = DEFAULT_STOCK_INIT,
    parameter logic [NUM_PROD-1:0][CREDIT_W-1:0] PRICES = DEFAULT_PRICES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coin_valid,
    input  logic [COIN_W-1:0]           coin,
    input  logic                        sel_valid,
    input  logic [$clog2(NUM_PROD)-1:0] sel,
    input  logic                        cancel,
    input  logic                        restock_valid,
    input  logic [$clog2(NUM_PROD)-1:0] restock_id,
    output logic                        out,
    output logic [$clog2(NUM_PROD)-1:0] out_id,
    output logic                        change_valid,
    output logic [CREDIT_W-1:0]         change,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        busy,
    output logic                        coin_reject,
    output logic                        err_funds,
    output logic                        err_soldout
);

    localparam int ID_W = $clog2(NUM_PROD);
    localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                out_q, out_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                busy_q, busy_d;
    logic                coin_reject_q, coin_reject_d;
    logic                err_funds_q, err_funds_d;
    logic                err_soldout_q, err_soldout_d;

    logic [NUM_PROD-1:0] empty;
    logic                dec_valid;
    logic                restock_en;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] price;

    vm_stock_bank #(
        .NUM_PROD  (NUM_PROD),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_id       (sel),
        .restock_valid(restock_en),
        .restock_id   (restock_id),
        .empty        (empty)
    );

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        out_d          = 1'b0;
        out_id_d       = '0;
        change_valid_d = 1'b0;
        change_d       = '0;
        coin_reject_d  = 1'b0;
        err_funds_d    = 1'b0;
        err_soldout_d  = 1'b0;
        dec_valid      = 1'b0;
        restock_en     = 1'b0;
        price          = PRICES[sel];
        // One extra bit so an overflowing coin is detectable rather than wrapping.
        coin_sum       = {1'b0, credit_q} + (CREDIT_W+1)'(coin);

        unique case (state_q)
            ST_IDLE, ST_CREDIT: begin
                // Cancel with nothing held is not an event, so it lets lower-priority inputs through.
                if (cancel && (state_q == ST_CREDIT)) begin
                    coin_reject_d  = coin_valid;
                    change_valid_d = 1'b1;
                    change_d       = credit_q;
                    credit_d       = '0;
                    state_d        = ST_CHANGE;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (empty[sel]) begin
                        err_soldout_d = 1'b1;
                    end else if (credit_q < price) begin
                        err_funds_d = 1'b1;
                    end else begin
                        out_d     = 1'b1;
                        out_id_d  = sel;
                        credit_d  = credit_q - price;
                        dec_valid = 1'b1;
                        state_d   = ST_DISPENSE;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= MAX_CREDIT) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (restock_valid && (state_q == ST_IDLE)) begin
                    restock_en = 1'b1;
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (credit_q != '0) begin
                    change_valid_d = 1'b1;
                    change_d       = credit_q;
                    credit_d       = '0;
                    state_d        = ST_CHANGE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                coin_reject_d = coin_valid;
                state_d       = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            out_q          <= 1'b0;
            out_id_q       <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            busy_q         <= 1'b0;
            coin_reject_q  <= 1'b0;
            err_funds_q    <= 1'b0;
            err_soldout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            out_q          <= out_d;
            out_id_q       <= out_id_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            busy_q         <= busy_d;
            coin_reject_q  <= coin_reject_d;
            err_funds_q    <= err_funds_d;
            err_soldout_q  <= err_soldout_d;
        end
    end

    assign out          = out_q;
    assign out_id       = out_id_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
    assign coin_reject  = coin_reject_q;
    assign err_funds    = err_funds_q;
    assign err_soldout  = err_soldout_q;

endmodule
